// File: rtl/shift_frame_rx.sv
// shift_frame_rx: receives start/data/stop frames sampled on TICK and holds the last accepted word
// with a valid handshake and sticky framing and overrun flags.
module shift_frame_rx #(
    parameter int NBITS = 4
) (
    input  logic             CLK,
    input  logic             CLRN,
    input  logic             TICK,
    input  logic             SIN,
    input  logic             DIR,
    input  logic             ACK,
    input  logic             ERRCLR,
    output logic [NBITS-1:0] Q,
    output logic             VALID,
    output logic             BUSY,
    output logic             FERR,
    output logic             OVR
);
    localparam int CW = $clog2(NBITS + 1);

    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [NBITS-1:0]  sh, sh_n, q_n;
    logic              dir_r, dir_n, valid_n, ferr_n, ovr_n;
    logic              done, bad, load;

    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            state <= IDLE;
            cnt   <= '0;
            sh    <= '0;
            dir_r <= 1'b0;
            Q     <= '0;
            VALID <= 1'b0;
            FERR  <= 1'b0;
            OVR   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sh    <= sh_n;
            dir_r <= dir_n;
            Q     <= q_n;
            VALID <= valid_n;
            FERR  <= ferr_n;
            OVR   <= ovr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        dir_n   = dir_r;
        done    = (state == STOP) && TICK && SIN;
        bad     = (state == STOP) && TICK && !SIN;
        // an ACK in the completion cycle frees Q for the new word
        load    = done && (!VALID || ACK);
        if (TICK) begin
            case (state)
                IDLE: if (!SIN) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    dir_n   = DIR;
                end
                DATA: begin
                    sh_n  = dir_r ? {sh[NBITS-2:0], SIN} : {SIN, sh[NBITS-1:1]};
                    cnt_n = cnt + 1'b1;
                    if (cnt == CW'(NBITS - 1)) state_n = STOP;
                end
                default: state_n = IDLE;
            endcase
        end
        q_n     = load ? sh : Q;
        valid_n = load ? 1'b1 : (ACK ? 1'b0 : VALID);
        ferr_n  = bad | (FERR & !ERRCLR);
        ovr_n   = (done & VALID & !ACK) | (OVR & !ERRCLR);
    end

    assign BUSY = (state != IDLE);
endmodule

// File: doc/shift_frame_rx.md
SHIFT_FRAME_RX -- requirements
Module: shift_frame_rx

Interface
REQ-001 Parameter: NBITS, 4, data bits per frame and width of Q; legal range 2..16.
REQ-002 CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 CLRN  input  1  reset, asynchronous, active-low.
REQ-004 TICK  input  1  bit-period enable, one CLK cycle high per bit, from the clock divider.
REQ-005 SIN  input  1  serial line from the shift-register transmitter output; idles high.
REQ-006 DIR  input  1  bit order: 0 = first data bit to Q[0] (right shift); 1 = first data bit to Q[NBITS-1] (left shift).
REQ-007 ACK  input  1  consumer has taken Q.
REQ-008 ERRCLR  input  1  clears the sticky error flags.
REQ-009 Q  output  NBITS  last accepted data word.
REQ-010 VALID  output  1  Q holds an unacknowledged word.
REQ-011 BUSY  output  1  frame in progress (state not IDLE).
REQ-012 FERR  output  1  sticky framing error.
REQ-013 OVR  output  1  sticky overrun.

Function
REQ-014 Frame on SIN shall be one start bit (0), NBITS data bits, one stop bit (1), one bit per TICK, sampled on the CLK edge where TICK=1.
REQ-015 With TICK=0, state, counters and shift register shall hold; ACK and ERRCLR shall still act.
REQ-016 States IDLE, DATA, STOP; IDLE->DATA on TICK with SIN=0, bit count cleared, DIR captured.
REQ-017 In IDLE, a TICK with SIN=1 shall keep IDLE.
REQ-018 In DATA, each TICK shall shift SIN into the internal register per captured DIR and increment the count; after the NBITS-th data bit the state shall go to STOP.
REQ-019 DIR changes after the start bit shall not affect the frame in progress.
REQ-020 In STOP, a TICK with SIN=1 shall complete the frame and return to IDLE.
REQ-021 On completion with VALID=0, or VALID=1 and ACK=1 that cycle, Q shall load the word and VALID shall be 1 from the next cycle; latency is 0 cycles after the stop-bit edge.
REQ-022 On completion with VALID=1 and ACK=0, the word shall be discarded, Q held, VALID held, and OVR set.
REQ-023 In STOP, a TICK with SIN=0 shall set FERR, discard the word, leave Q/VALID unchanged, and return to IDLE; that bit shall not count as a start bit.
REQ-024 ACK=1 with VALID=1 and no completion that cycle shall clear VALID at the next edge; ACK with VALID=0 has no effect.
REQ-025 ERRCLR=1 shall clear FERR and OVR at the next edge unless a new error occurs the same cycle, which shall win.
REQ-026 BUSY shall be 1 in DATA and STOP, 0 in IDLE.

Reset
REQ-027 CLRN=0 shall immediately force IDLE, count 0, shift register 0, Q=0, VALID=0, BUSY=0, FERR=0, OVR=0, independent of CLK.
REQ-028 Reset mid-frame shall abort the frame with no partial Q update; after release reception restarts at the next start bit.

Verification
REQ-029 DIR=0, TICKs with SIN=0,1,0,1,1,1 -> after 6th TICK Q=4'hD, VALID=1, FERR=0, BUSY=0.
REQ-030 DIR=1, same SIN sequence -> Q=4'hB, VALID=1.
REQ-031 SIN=0,1,1,1,1,0 (stop bit 0) -> FERR=1, VALID=0, Q=4'h0, state IDLE; ERRCLR pulse -> FERR=0.
REQ-032 Two valid frames (4'hD then 4'h3, DIR=0) with no ACK -> Q=4'hD, VALID=1, OVR=1; ACK pulse -> VALID=0, OVR stays 1.
REQ-033 ACK asserted in the same cycle as 4'h3 frame completion while Q=4'hD valid -> Q=4'h3, VALID=1, OVR=0.
REQ-034 CLRN pulsed low after 2nd data bit -> all outputs 0 at once; following full frame 4'h6 received correctly; DIR toggled mid-frame has no effect.
